// File: rtl/wb_arb_2m1s.sv
// wb_arb_2m1s: two-master, one-slave Wishbone classic arbiter.
// Round-robin grant that is held for the whole cyc envelope, ack/err routed
// only to the owner, and a watchdog that turns a stalled beat into an err pulse.
module wb_arb_2m1s #(
   parameter int TIMEOUT = 255,
   parameter int AW      = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [31:0]   m0_dat_i,
   input  logic [3:0]    m0_sel_i,
   input  logic          m0_we_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   output logic [31:0]   m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [31:0]   m1_dat_i,
   input  logic [3:0]    m1_sel_i,
   input  logic          m1_we_i,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   output logic [31:0]   m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [AW-1:0] s_adr_o,
   output logic [31:0]   s_dat_o,
   output logic [3:0]    s_sel_o,
   output logic          s_we_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   input  logic [31:0]   s_dat_i,
   input  logic          s_ack_i,
   output logic [1:0]    gnt_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   // Watchdog fires when the counter reaches this value without an ack.
   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     state_next;
   logic       last;
   logic [7:0] wd;
   logic       own_stb;
   logic       timeout_hit;

   // Next owner: round-robin on ties from IDLE, no preemption, direct handoff.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_next = last ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               state_next = GNT0;
            end else if (m1_cyc_i) begin
               state_next = GNT1;
            end
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               state_next = m1_cyc_i ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               state_next = m0_cyc_i ? GNT0 : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Owner register plus the most recent owner, updated on each grant entry.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_next;
         if (state_next == GNT0 && state != GNT0) begin
            last <= 1'b0;
         end else if (state_next == GNT1 && state != GNT1) begin
            last <= 1'b1;
         end
      end
   end

   // Slave-side mux driven purely by the owner; strobe is killed on timeout.
   always_comb begin
      s_adr_o     = '0;
      s_dat_o     = '0;
      s_sel_o     = '0;
      s_we_o      = 1'b0;
      s_cyc_o     = 1'b0;
      own_stb     = 1'b0;
      gnt_o       = 2'b00;
      case (state)
         GNT0: begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            own_stb = m0_stb_i;
            gnt_o   = 2'b01;
         end
         GNT1: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            own_stb = m1_stb_i;
            gnt_o   = 2'b10;
         end
         default: ;
      endcase
      timeout_hit = own_stb && !s_ack_i && (wd == WD_LAST);
      s_stb_o     = own_stb && !timeout_hit;
   end

   // Terminations go only to the owner; an ack in the timeout cycle wins.
   always_comb begin
      m0_dat_o = s_dat_i;
      m1_dat_o = s_dat_i;
      m0_ack_o = s_ack_i && gnt_o[0] && s_stb_o;
      m1_ack_o = s_ack_i && gnt_o[1] && s_stb_o;
      m0_err_o = gnt_o[0] && timeout_hit;
      m1_err_o = gnt_o[1] && timeout_hit;
   end

   // Watchdog counts consecutive unacknowledged strobed cycles of one owner.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wd <= 8'd0;
      end else if (!s_stb_o || s_ack_i || (state_next != state)) begin
         wd <= 8'd0;
      end else begin
         wd <= wd + 8'd1;
      end
   end

endmodule

// File: tb/tb_wb_arb_2m1s.sv
// tb_wb_arb_2m1s: self-checking bench for the two-master Wishbone arbiter.
// A small RAM model plays the slave; per-master scoreboards hold expected beats.
module tb_wb_arb_2m1s;

   localparam int AW = 32;
   localparam int TO = 8;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [AW-1:0] m0_adr_i, m1_adr_i;
   logic [31:0]   m0_dat_i, m1_dat_i;
   logic [3:0]    m0_sel_i, m1_sel_i;
   logic          m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
   logic [31:0]   m0_dat_o, m1_dat_o;
   logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
   logic [AW-1:0] s_adr_o;
   logic [31:0]   s_dat_o;
   logic [3:0]    s_sel_o;
   logic          s_we_o, s_cyc_o, s_stb_o;
   logic [31:0]   s_dat_i;
   logic          s_ack_i;
   logic [1:0]    gnt_o;

   logic          slave_rst_n;
   logic          ack_en;
   logic [31:0]   mem     [0:511];
   logic [31:0]   ref_mem [0:511];

   typedef struct {
      bit          we;
      logic [31:0] data;
   } sb_t;

   typedef struct {
      int          m;
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [1:0]  gnt;
   } vec_t;

   sb_t        sb0[$];
   sb_t        sb1[$];
   logic [1:0] gnt_log[$];
   logic [1:0] last_logged;
   bit         log_en;
   int         m1_ack_count;
   int         tests_run;
   int         tests_failed;
   vec_t       vecs[5];
   logic [1:0] rr_exp[4];

   always #5 clk_i = ~clk_i;

   wb_arb_2m1s #(.TIMEOUT(TO), .AW(AW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
      .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
      .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
      .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
   );

   // RAM slave with one-cycle registered ack; ack_en stalls it for the watchdog.
   always @(posedge clk_i) begin
      if (!slave_rst_n) begin
         s_ack_i <= 1'b0;
         s_dat_i <= 32'h5A5A_0F0F;
         for (int i = 0; i < 512; i++) mem[i] <= '0;
      end else if (ack_en && s_cyc_o && s_stb_o && !s_ack_i) begin
         s_ack_i <= 1'b1;
         if (s_we_o) begin
            for (int b = 0; b < 4; b++) begin
               if (s_sel_o[b]) mem[s_adr_o[10:2]][b*8 +: 8] <= s_dat_o[b*8 +: 8];
            end
         end else begin
            s_dat_i <= mem[s_adr_o[10:2]];
         end
      end else begin
         s_ack_i <= 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic pop_and_check(input int m);
      sb_t e;
      if ((m == 0 && sb0.size() == 0) || (m == 1 && sb1.size() == 0)) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL unexpected_ack_m%0d: got ack, expected none", m);
      end else begin
         e = (m == 0) ? sb0.pop_front() : sb1.pop_front();
         checkOutput($sformatf("ack_owner_m%0d", m), gnt_o, (m == 0) ? 2'b01 : 2'b10);
         if (!e.we) begin
            checkOutput($sformatf("rdata_m%0d", m), (m == 0) ? m0_dat_o : m1_dat_o, e.data);
         end
      end
   endtask

   // Monitor: pops the owning master's scoreboard on each ack and logs grants.
   always @(negedge clk_i) begin
      if (m0_ack_o === 1'b1) pop_and_check(0);
      if (m1_ack_o === 1'b1) begin
         m1_ack_count++;
         pop_and_check(1);
      end
      if (log_en && gnt_o != 2'b00 && gnt_o != last_logged) begin
         gnt_log.push_back(gnt_o);
         last_logged = gnt_o;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_master(input int m, input bit cyc, input bit stb, input bit we,
                             input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel);
      if (m == 0) begin
         m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
         m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
      end else begin
         m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
         m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
      end
   endtask

   task automatic applyStimulus(input int m, input bit we, input logic [31:0] adr,
                                input logic [31:0] dat, input logic [3:0] sel);
      sb_t e;
      set_master(m, 1'b1, 1'b1, we, adr, dat, sel);
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (sel[b]) ref_mem[adr[10:2]][b*8 +: 8] = dat[b*8 +: 8];
         end
         e.we   = 1'b1;
         e.data = dat;
      end else begin
         e.we   = 1'b0;
         e.data = ref_mem[adr[10:2]];
      end
      if (m == 0) sb0.push_back(e);
      else        sb1.push_back(e);
   endtask

   task automatic finish_beat(input int m, input bit hold, input logic [1:0] exp_gnt);
      bit got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (((m == 0) ? m0_ack_o : m1_ack_o) === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput($sformatf("beat_ack_m%0d", m), got, 1'b1);
      if (got) checkOutput($sformatf("beat_gnt_m%0d", m), gnt_o, exp_gnt);
      @(posedge clk_i);
      #1;
      if (m == 0) begin m0_stb_i = 1'b0; m0_cyc_i = hold; end
      else        begin m1_stb_i = 1'b0; m1_cyc_i = hold; end
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "[TB] global timeout");
   end

   initial begin
      tests_run = 0; tests_failed = 0; m1_ack_count = 0;
      log_en = 1'b0; last_logged = 2'b00;
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;
      vecs[0] = '{0, 1'b1, 32'h010, 32'hDEAD_BEEF, 4'hF, 2'b01};
      vecs[1] = '{0, 1'b0, 32'h010, 32'h0,         4'hF, 2'b01};
      vecs[2] = '{0, 1'b1, 32'h014, 32'hCAFE_F00D, 4'h5, 2'b01};
      vecs[3] = '{0, 1'b0, 32'h014, 32'h0,         4'hF, 2'b01};
      vecs[4] = '{0, 1'b0, 32'h010, 32'h0,         4'hF, 2'b01};
      rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

      // Reset held with both masters requesting.
      rst_i = 1'b0; slave_rst_n = 1'b0; ack_en = 1'b1;
      set_master(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_master(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("rst_gnt", gnt_o, 2'b00);
      checkOutput("rst_s_adr", s_adr_o, 32'h0);
      checkOutput("rst_s_dat", s_dat_o, 32'h0);
      checkOutput("rst_s_ctrl", {s_sel_o, s_we_o, s_cyc_o, s_stb_o}, 7'h0);
      checkOutput("rst_ack_err", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'h0);
      checkOutput("rst_m0_dat", m0_dat_o, 32'h5A5A_0F0F);
      checkOutput("rst_m1_dat", m1_dat_o, 32'h5A5A_0F0F);
      rst_i = 1'b1; slave_rst_n = 1'b1;
      tick();
      checkOutput("rst_first_gnt", gnt_o, 2'b01);
      m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
      tick();
      checkOutput("idle_gnt", gnt_o, 2'b00);

      // Single master table: writes with byte selects and read-backs.
      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].m, vecs[v].we, vecs[v].adr, vecs[v].dat, vecs[v].sel);
         finish_beat(vecs[v].m, 1'b0, vecs[v].gnt);
         tick();
      end
      checkOutput("single_m1_ack_count", m1_ack_count, 0);

      // Simultaneous one-beat cycles from a fresh reset: grants alternate.
      rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      last_logged = 2'b00;
      log_en = 1'b1;
      fork
         begin
            applyStimulus(0, 1'b1, 32'h004, 32'h1111_1111, 4'hF);
            finish_beat(0, 1'b0, 2'b01);
            tick();
            applyStimulus(0, 1'b0, 32'h004, 32'h0, 4'hF);
            finish_beat(0, 1'b0, 2'b01);
         end
         begin
            applyStimulus(1, 1'b1, 32'h008, 32'h2222_2222, 4'hF);
            finish_beat(1, 1'b0, 2'b10);
            tick();
            applyStimulus(1, 1'b0, 32'h008, 32'h0, 4'hF);
            finish_beat(1, 1'b0, 2'b10);
         end
      join
      log_en = 1'b0;
      checkOutput("rr_len", gnt_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < gnt_log.size()) checkOutput($sformatf("rr_gnt_%0d", i), gnt_log[i], rr_exp[i]);
      end
      tick();

      // m1 holds cyc over four beats while m0 waits; then handoff without a gap.
      applyStimulus(1, 1'b1, 32'h100, 32'hA000_0000, 4'hF);
      tick();
      checkOutput("held_gnt_m1", gnt_o, 2'b10);
      applyStimulus(0, 1'b0, 32'h010, 32'h0, 4'hF);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) applyStimulus(1, 1'b1, 32'h100 + 32'(4*k), 32'hA000_0000 + 32'(k), 4'hF);
         finish_beat(1, (k < 3), 2'b10);
         checkOutput($sformatf("held_no_m0_%0d", k), gnt_o, 2'b10);
      end
      tick();
      checkOutput("held_handoff", gnt_o, 2'b01);
      finish_beat(0, 1'b0, 2'b01);
      tick();

      // Watchdog: stalled slave, err exactly TO cycles after m0 first strobes.
      ack_en = 1'b0;
      set_master(0, 1'b1, 1'b1, 1'b0, 32'h040, 32'h0, 4'hF);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk_i);
         #2;
         checkOutput($sformatf("wd_err_k%0d", k), m0_err_o, (k == TO));
         if (k == TO - 1) checkOutput("wd_stb_before", s_stb_o, 1'b1);
         if (k == TO) begin
            checkOutput("wd_stb_forced", s_stb_o, 1'b0);
            checkOutput("wd_gnt_kept", gnt_o, 2'b01);
            checkOutput("wd_m1_err", m1_err_o, 1'b0);
         end
      end
      set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      ack_en = 1'b1;
      tick();
      tick();

      // Reset while m1 is waiting on a stalled beat; ack arrives after reset.
      ack_en = 1'b0;
      set_master(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
      tick();
      checkOutput("mrst_gnt_m1", gnt_o, 2'b10);
      tick();
      rst_i = 1'b0;
      ack_en = 1'b1;
      tick();
      checkOutput("mrst_s_cyc", s_cyc_o, 1'b0);
      checkOutput("mrst_s_stb", s_stb_o, 1'b0);
      checkOutput("mrst_m1_ack", m1_ack_o, 1'b0);
      checkOutput("mrst_gnt", gnt_o, 2'b00);
      rst_i = 1'b1;
      m1_stb_i = 1'b0;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b0;
      tick();
      checkOutput("mrst_tie_m0", gnt_o, 2'b01);
      m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
      tick();
      tick();

      checkOutput("sb0_empty", sb0.size(), 0);
      checkOutput("sb1_empty", sb1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
